// File: rtl/alu_a_sequencer.sv
// ---------------------------------------------------------------------------
// alu_a_sequencer
//   Control FSM that sequences the ALU A-bus operand mux select and the
//   datapath register write enables (IDR, MDR, Rcol, Rrow). A burst moves
//   iter_count operands from one A-bus source to one destination register,
//   one iteration being SELECT -> EXEC (EXEC_CYCLES cycles) -> WB.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   start       in   burst request, sampled only in IDLE
//   src_sel     in   A-bus source: 0=zero,1=IDR,2=MDR,3=Rcol,4=Rrow (5-7 invalid)
//   dst_sel     in   writeback target: 0=IDR,1=MDR,2=Rcol,3=Rrow
//   iter_count  in   number of iterations in the burst
//   abort       in   cancel the burst in progress
//   alu_a_sel   out  ALU_Mux_A select
//   write_*     out  register write enables (one-hot, only in WB)
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse at burst completion
//   err         out  one-cycle pulse on a start with an invalid src_sel
//   iter_idx    out  0-based index of the current iteration
// ---------------------------------------------------------------------------
module alu_a_sequencer #(
    parameter int CNT_W       = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       src_sel,
    input  logic [1:0]       dst_sel,
    input  logic [CNT_W-1:0] iter_count,
    input  logic             abort,
    output logic [2:0]       alu_a_sel,
    output logic             write_idr,
    output logic             write_mdr,
    output logic             write_rcol,
    output logic             write_rrow,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_idx
);

    localparam int EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // One-hot write enable vector {rrow, rcol, mdr, idr} for a destination code
    function automatic logic [3:0] dst_onehot(input logic [1:0] d);
        logic [3:0] oh;
        case (d)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    state_t            state_q,     state_d;
    logic [2:0]        src_q,       src_d;
    logic [1:0]        dst_q,       dst_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [CNT_W-1:0]  iter_idx_q,  iter_idx_d;
    logic [EXEC_W-1:0] exec_cnt_q,  exec_cnt_d;
    logic [2:0]        alu_a_sel_q, alu_a_sel_d;
    logic [3:0]        wr_q,        wr_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        count_d     = count_q;
        iter_idx_d  = iter_idx_q;
        exec_cnt_d  = exec_cnt_q;
        alu_a_sel_d = alu_a_sel_q;
        wr_d        = 4'b0000;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort wins over start; a dropped start raises nothing
                if (start && !abort) begin
                    if (src_sel > 3'd4) begin
                        err_d = 1'b1;
                    end else if (iter_count == {CNT_W{1'b0}}) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        busy_d      = 1'b1;
                        alu_a_sel_d = 3'd0;
                        iter_idx_d  = {CNT_W{1'b0}};
                    end else begin
                        state_d     = S_SELECT;
                        src_d       = src_sel;
                        dst_d       = dst_sel;
                        count_d     = iter_count;
                        iter_idx_d  = {CNT_W{1'b0}};
                        alu_a_sel_d = src_sel;
                        busy_d      = 1'b1;
                    end
                end else begin
                    busy_d      = 1'b0;
                    alu_a_sel_d = 3'd0;
                end
            end
            S_SELECT: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    alu_a_sel_d = 3'd0;
                end else begin
                    state_d    = S_EXEC;
                    exec_cnt_d = {EXEC_W{1'b0}};
                end
            end
            S_EXEC: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    alu_a_sel_d = 3'd0;
                end else if (exec_cnt_q == EXEC_LAST) begin
                    state_d = S_WB;
                    wr_d    = dst_onehot(dst_q);
                end else begin
                    exec_cnt_d = exec_cnt_q + EXEC_W'(1);
                end
            end
            S_WB: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    alu_a_sel_d = 3'd0;
                end else if (iter_idx_q == (count_q - CNT_W'(1))) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    alu_a_sel_d = 3'd0;
                end else begin
                    state_d    = S_SELECT;
                    iter_idx_d = iter_idx_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                alu_a_sel_d = 3'd0;
            end
            default: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                alu_a_sel_d = 3'd0;
            end
        endcase
    end

    // State and registered-output flops with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            src_q       <= 3'd0;
            dst_q       <= 2'd0;
            count_q     <= {CNT_W{1'b0}};
            iter_idx_q  <= {CNT_W{1'b0}};
            exec_cnt_q  <= {EXEC_W{1'b0}};
            alu_a_sel_q <= 3'd0;
            wr_q        <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            count_q     <= count_d;
            iter_idx_q  <= iter_idx_d;
            exec_cnt_q  <= exec_cnt_d;
            alu_a_sel_q <= alu_a_sel_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // abort suppresses a pending writeback within the same cycle
    assign write_idr  = wr_q[0] & ~abort;
    assign write_mdr  = wr_q[1] & ~abort;
    assign write_rcol = wr_q[2] & ~abort;
    assign write_rrow = wr_q[3] & ~abort;
    assign alu_a_sel  = alu_a_sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign iter_idx   = iter_idx_q;

endmodule

// File: tb/tb_alu_a_sequencer.sv
module tb_alu_a_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] src_sel;
    logic [1:0] dst_sel;
    logic [3:0] iter_count;
    logic       abort;
    logic [2:0] alu_a_sel;
    logic       write_idr, write_mdr, write_rcol, write_rrow;
    logic       busy, done, err;
    logic [3:0] iter_idx;

    int total = 0;
    int bad   = 0;

    alu_a_sequencer #(.CNT_W(4), .EXEC_CYCLES(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_sel    (src_sel),
        .dst_sel    (dst_sel),
        .iter_count (iter_count),
        .abort      (abort),
        .alu_a_sel  (alu_a_sel),
        .write_idr  (write_idr),
        .write_mdr  (write_mdr),
        .write_rcol (write_rcol),
        .write_rrow (write_rrow),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .iter_idx   (iter_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs for one cycle plus the outputs expected during that same cycle
    // wr is {rrow, rcol, mdr, idr}
    typedef struct {
        logic       st;
        logic [2:0] src;
        logic [1:0] dst;
        logic [3:0] cnt;
        logic       ab;
        logic [2:0] alu;
        logic [3:0] wr;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic [2:0] src, input logic [1:0] dst,
                       input logic [3:0] cnt, input logic ab, input logic [2:0] alu,
                       input logic [3:0] wr, input logic b, input logic d, input logic e,
                       input logic [3:0] idx);
        vec_t v;
        v.st = st; v.src = src; v.dst = dst; v.cnt = cnt; v.ab = ab;
        v.alu = alu; v.wr = wr; v.busy = b; v.done = d; v.err = e; v.idx = idx;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int n, input logic [2:0] alu,
                         input logic [3:0] wr, input logic b, input logic d,
                         input logic e, input logic [3:0] idx);
        logic [13:0] got, exp;
        got = {alu_a_sel, write_rrow, write_rcol, write_mdr, write_idr, busy, done, err, iter_idx};
        exp = {alu, wr, b, d, e, idx};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got alu=%0d wr=%b busy=%b done=%b err=%b idx=%0d want alu=%0d wr=%b busy=%b done=%b err=%b idx=%0d",
                     nm, n, got[13:11], got[10:7], got[6], got[5], got[4], got[3:0],
                     exp[13:11], exp[10:7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // drive one cycle's inputs, check that cycle's outputs, advance past the edge
    task automatic apply(input vec_t v, input string nm, input int n);
        start = v.st; src_sel = v.src; dst_sel = v.dst; iter_count = v.cnt; abort = v.ab;
        #1;
        check(nm, n, v.alu, v.wr, v.busy, v.done, v.err, v.idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // count=1 src=2 dst=Rcol
        add(1'b1, 3'd2, 2'd2, 4'd1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd2, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd2, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd2, 4'b0100, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
        // count=3 src=4 dst=MDR
        add(1'b1, 3'd4, 2'd1, 4'd3, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd4, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd4, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd4, 4'b0010, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd4, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd4, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd4, 4'b0010, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd4, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd2);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd4, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd2);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd4, 4'b0010, 1'b1, 1'b0, 1'b0, 4'd2);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd2);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd2);
        // invalid source -> err pulse only
        add(1'b1, 3'd6, 2'd0, 4'd1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd2);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'd2);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd2);
        // abort together with start drops the start (invalid and valid source)
        add(1'b1, 3'd7, 2'd0, 4'd1, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd2);
        add(1'b1, 3'd1, 2'd0, 4'd1, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd2);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd2);
        // count=2 src=1 dst=Rrow, abort in second WB
        add(1'b1, 3'd1, 2'd3, 4'd2, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd2);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd1, 4'b1000, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 3'd1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1);
        // count=2 src=3 dst=IDR, start held high with other inputs during burst
        add(1'b1, 3'd3, 2'd0, 4'd2, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1);
        add(1'b1, 3'd4, 2'd3, 4'd5, 1'b0, 3'd3, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 3'd6, 2'd3, 4'd5, 1'b0, 3'd3, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 3'd4, 2'd3, 4'd5, 1'b0, 3'd3, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 3'd4, 2'd3, 4'd5, 1'b0, 3'd3, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b1, 3'd4, 2'd3, 4'd5, 1'b0, 3'd3, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b1, 3'd4, 2'd3, 4'd5, 1'b0, 3'd3, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b1, 3'd4, 2'd3, 4'd5, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd1);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1);
        // count=0 -> done next cycle, no writes
        add(1'b1, 3'd1, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd0);
        add(1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);

        reset = 1'b1; start = 1'b0; src_sel = 3'd0; dst_sel = 2'd0;
        iter_count = 4'd0; abort = 1'b0;
        #1;
        check("reset", 0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], "vec", i);
        end

        // reset during EXEC of the second iteration of a count=3 burst
        v.st = 1'b1; v.src = 3'd3; v.dst = 2'd2; v.cnt = 4'd3; v.ab = 1'b0;
        v.alu = 3'd0; v.wr = 4'b0000; v.busy = 1'b0; v.done = 1'b0; v.err = 1'b0; v.idx = 4'd0;
        apply(v, "rst_seq", 0);
        v.st = 1'b0; v.alu = 3'd3; v.busy = 1'b1;
        apply(v, "rst_seq", 1);
        apply(v, "rst_seq", 2);
        v.wr = 4'b0100;
        apply(v, "rst_seq", 3);
        v.wr = 4'b0000; v.idx = 4'd1;
        apply(v, "rst_seq", 4);
        #1;
        check("rst_seq", 5, 3'd3, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async", 0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        check("rst_async", 1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        v.alu = 3'd0; v.busy = 1'b0; v.idx = 4'd0;
        for (int i = 0; i < 4; i++) begin
            apply(v, "rst_after", i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
